// File: rtl/sel_decoder_n.sv
// -----------------------------------------------------------------------------
// sel_decoder_n
//
// Registered SEL_W-to-2^SEL_W one-hot select decoder for chip-selects,
// LED/column strobes and mux enables. A valid/ready command either latches a
// line (held until replaced) or fires a timed pulse of HOLD_CYCLES cycles.
// An optional auto-scan walks every line in turn, HOLD_CYCLES cycles each.
//
// Build option:
//   DECODER_SCAN_EN  when defined, the SCAN state, step counter and scan_done
//                    are compiled in. When undefined, scan_start is ignored
//                    and scan_done is tied low.
//
// Parameters:
//   SEL_W        select width; output width is 2**SEL_W
//   HOLD_CYCLES  pulse length and per-step scan dwell, 1..255
//   ACTIVE_LOW   1 inverts the output (inactive pattern is all ones)
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   s            select code
//   in_valid     command valid
//   in_ready     command accepted when in_valid & in_ready at a rising edge
//   mode         0 = latch, 1 = pulse (sampled only on a transfer)
//   en           output gate, masks d combinationally, timers keep running
//   scan_start   single-cycle scan request, honoured only in IDLE
//   d            one-hot (or one-cold) decoded output
//   busy         high while pulsing or scanning
//   scan_done    one-cycle pulse in the first IDLE cycle after a scan
// -----------------------------------------------------------------------------
module sel_decoder_n #(
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      s,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic                  en,
  input  logic                  scan_start,
  output logic [2**SEL_W-1:0]   d,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int         OUT_W       = 2**SEL_W;
  // Reloading with HOLD_CYCLES-1 and leaving on zero gives exactly
  // HOLD_CYCLES active cycles, including the cycle right after the load.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_SCAN} state_e;
`else
  typedef enum logic {ST_IDLE, ST_PULSE} state_e;
`endif

  state_e           state_q, state_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             scan_go;
  logic             take;

`ifdef DECODER_SCAN_EN
  localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(OUT_W - 1);

  logic [SEL_W-1:0] step_q, step_d;
  logic             scan_done_q, scan_done_d;

  assign scan_go   = scan_start;
  assign scan_done = scan_done_q;
`else
  logic unused_scan_start;

  assign unused_scan_start = scan_start;
  assign scan_go           = 1'b0;
  assign scan_done         = 1'b0;
`endif

  // A scan request in IDLE wins over a command; dropping ready here keeps the
  // command pending instead of silently discarding it.
  assign in_ready = (state_q == ST_IDLE) && !scan_go;
  assign busy     = (state_q != ST_IDLE);
  assign take     = in_valid && in_ready;

  assign d = en ? (ACTIVE_LOW ? ~d_q : d_q) : {OUT_W{ACTIVE_LOW}};

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
`ifdef DECODER_SCAN_EN
    step_d      = step_q;
    scan_done_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef DECODER_SCAN_EN
        if (scan_go) begin
          state_d = ST_SCAN;
          step_d  = '0;
          cnt_d   = HOLD_RELOAD;
          d_d     = OUT_W'(1);
        end else
`endif
        if (take) begin
          d_d = OUT_W'(1) << s;
          if (mode) begin
            cnt_d   = HOLD_RELOAD;
            state_d = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          d_d     = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef DECODER_SCAN_EN
      ST_SCAN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (step_q == LAST_STEP) begin
          d_d         = '0;
          state_d     = ST_IDLE;
          scan_done_d = 1'b1;
        end else begin
          step_d = step_q + SEL_W'(1);
          cnt_d  = HOLD_RELOAD;
          d_d    = OUT_W'(1) << step_d;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      cnt_q   <= 8'd0;
`ifdef DECODER_SCAN_EN
      step_q      <= '0;
      scan_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
`ifdef DECODER_SCAN_EN
      step_q      <= step_d;
      scan_done_q <= scan_done_d;
`endif
    end
  end

endmodule

// File: tb/tb_sel_decoder_n.sv
// -----------------------------------------------------------------------------
// tb_sel_decoder_n
//
// Two decoders share one stimulus stream: A (HOLD_CYCLES=4, active high) and
// B (HOLD_CYCLES=1, active low). A behavioural model per instance tracks the
// active line, remaining pulse time and elapsed scan time; a compare process
// checks every output on every falling clock edge. Directed sections pin the
// model with hand-computed literals, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_sel_decoder_n;

  localparam int OUT_W = 8;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] s = '0;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       en = 1'b1;
  logic       scan_start = 1'b0;

  logic [7:0] d_a, d_b;
  logic       rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  sel_decoder_n #(.SEL_W(3), .HOLD_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(s), .in_valid(in_valid), .in_ready(rdy_a),
    .mode(mode), .en(en), .scan_start(scan_start), .d(d_a), .busy(busy_a),
    .scan_done(done_a));

  sel_decoder_n #(.SEL_W(3), .HOLD_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(s), .in_valid(in_valid), .in_ready(rdy_b),
    .mode(mode), .en(en), .scan_start(scan_start), .d(d_b), .busy(busy_b),
    .scan_done(done_b));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 pulse, 2 scan. line = -1 means nothing active.
  int hold[2]    = '{4, 1};
  bit al[2]      = '{1'b0, 1'b1};
  int m_phase[2] = '{0, 0};
  int m_line[2]  = '{-1, -1};
  int m_rem[2]   = '{0, 0};
  int m_t[2]     = '{0, 0};
  bit m_done[2]  = '{1'b0, 1'b0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_phase[k] = 0; m_line[k] = -1; m_rem[k] = 0; m_t[k] = 0; m_done[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        case (m_phase[k])
          0: begin
            if (SCAN_EN && scan_start) begin
              m_phase[k] = 2; m_t[k] = 0; m_line[k] = 0;
            end else if (in_valid) begin
              m_line[k] = int'(s);
              if (mode) begin
                m_phase[k] = 1; m_rem[k] = hold[k];
              end
            end
          end
          1: begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
              m_line[k] = -1; m_phase[k] = 0;
            end
          end
          default: begin
            m_t[k]++;
            if (m_t[k] == OUT_W * hold[k]) begin
              m_line[k] = -1; m_phase[k] = 0; m_done[k] = 1'b1;
            end else begin
              m_line[k] = m_t[k] / hold[k];
            end
          end
        endcase
      end
    end
  end

  function automatic logic [7:0] exp_d(input int k);
    logic [7:0] v;
    v = 8'h00;
    if (en && m_line[k] >= 0) v = 8'd1 << m_line[k];
    if (al[k]) v = ~v;
    return v;
  endfunction

  function automatic logic exp_rdy(input int k);
    return (m_phase[k] == 0) && !(SCAN_EN && scan_start);
  endfunction

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("d_a",     {24'h0, d_a},  {24'h0, exp_d(0)});
      check("d_b",     {24'h0, d_b},  {24'h0, exp_d(1)});
      check("rdy_a",   {31'h0, rdy_a},  {31'h0, exp_rdy(0)});
      check("rdy_b",   {31'h0, rdy_b},  {31'h0, exp_rdy(1)});
      check("busy_a",  {31'h0, busy_a}, {31'h0, m_phase[0] != 0});
      check("busy_b",  {31'h0, busy_b}, {31'h0, m_phase[1] != 0});
      check("done_a",  {31'h0, done_a}, {31'h0, m_done[0]});
      check("done_b",  {31'h0, done_b}, {31'h0, m_done[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    in_valid   = 1'b0;
    scan_start = 1'b0;
    n = 0;
    step();
    while ((busy_a || busy_b) && n < 60) begin
      step();
      n++;
    end
    check("idle_wait", {31'h0, busy_a | busy_b}, 32'h0);
  endtask

  initial begin
    int cnt8, cntb, first4, waited, cnt_busy, cnt_done, first_done, miss;
    logic [7:0] exp8;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_d_a",    {24'h0, d_a}, 32'h00);
    check("rst_d_b",    {24'h0, d_b}, 32'hFF);
    check("rst_rdy_a",  {31'h0, rdy_a}, 32'h1);
    check("rst_busy_a", {31'h0, busy_a}, 32'h0);
    check("rst_done_a", {31'h0, done_a}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // Latch 5, hold 20 cycles, then latch 0
    s = 3'b101; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("latch5_a", {24'h0, d_a}, 32'h20);
    check("latch5_b", {24'h0, d_b}, 32'hDF);
    repeat (20) step();
    check("latch5_held", {24'h0, d_a}, 32'h20);
    s = 3'b000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("latch0_a", {24'h0, d_a}, 32'h01);

    // Pulse 3 on A (4 cycles) with a command held during the pulse
    step();
    s = 3'b011; mode = 1'b1; in_valid = 1'b1;
    step();
    s = 3'b010; mode = 1'b0;
    cnt8 = 0; cntb = 0; first4 = -1;
    for (int i = 0; i < 10; i++) begin
      if (d_a == 8'h08) cnt8++;
      if (busy_a) cntb++;
      if (d_a == 8'h04 && first4 < 0) first4 = i;
      step();
    end
    in_valid = 1'b0;
    check("pulse_len",   cnt8, 4);
    check("pulse_busy",  cntb, 4);
    check("pulse_after", first4, 5);

    // Sweep all codes as single-cycle strobes on B
    wait_idle();
    for (int c = 0; c < 8; c++) begin
      s = 3'(c); mode = 1'b1; in_valid = 1'b1;
      #1;
      waited = 0;
      while (!rdy_b && waited < 5) begin
        step();
        #1;
        waited++;
      end
      check("sweep_rdy", {31'h0, rdy_b}, 32'h1);
      step();
      in_valid = 1'b0;
      exp8 = 8'd1 << c;
      check("sweep_strobe", {24'h0, d_b}, {24'h0, ~exp8});
      step();
      check("sweep_end", {24'h0, d_b}, 32'hFF);
    end

    // en masking with latched 6
    wait_idle();
    s = 3'b110; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    en = 1'b0;
    #1;
    check("en_lo_a", {24'h0, d_a}, 32'h00);
    check("en_lo_b", {24'h0, d_b}, 32'hFF);
    step();
    check("en_lo_a2", {24'h0, d_a}, 32'h00);
    en = 1'b1;
    #1;
    check("en_hi_a", {24'h0, d_a}, 32'h40);
    check("en_hi_b", {24'h0, d_b}, 32'hBF);

`ifdef DECODER_SCAN_EN
    // Scan with a simultaneous command: scan wins, command waits
    wait_idle();
    s = 3'b111; mode = 1'b0; in_valid = 1'b1; scan_start = 1'b1;
    #1;
    check("scan_rdy_low", {31'h0, rdy_a}, 32'h0);
    step();
    scan_start = 1'b0;
    cnt_busy = 0; cnt_done = 0; first_done = -1; miss = 0;
    for (int i = 0; i < 34; i++) begin
      if (busy_a) cnt_busy++;
      if (done_a) begin
        cnt_done++;
        if (first_done < 0) first_done = i;
      end
      if (i < 32 && d_a != (8'd1 << (i / 4))) miss++;
      step();
    end
    check("scan_walk",   miss, 0);
    check("scan_len",    cnt_busy, 32);
    check("scan_done_n", cnt_done, 1);
    check("scan_done_t", first_done, 32);
    check("scan_cmd",    {24'h0, d_a}, 32'h80);
    in_valid = 1'b0;

    // Reset mid-scan at step 3
    wait_idle();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    repeat (12) step();
    check("scan_step3", {24'h0, d_a}, 32'h08);
    rst_n = 1'b0;
    #1;
`else
    // Reset mid-pulse
    wait_idle();
    s = 3'b100; mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("pulse_mid", {24'h0, d_a}, 32'h10);
    rst_n = 1'b0;
    #1;
`endif
    check("abort_d_a",    {24'h0, d_a}, 32'h00);
    check("abort_d_b",    {24'h0, d_b}, 32'hFF);
    check("abort_done_a", {31'h0, done_a}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("abort_rdy_a",  {31'h0, rdy_a}, 32'h1);
    check("abort_done_a2", {31'h0, done_a}, 32'h0);

    // Randomized run
    for (int i = 0; i < 2000; i++) begin
      step();
      in_valid   = ($urandom_range(0, 3) != 0);
      s          = 3'($urandom_range(0, 7));
      mode       = 1'($urandom_range(0, 1));
      en         = ($urandom_range(0, 7) != 0);
      scan_start = ($urandom_range(0, 63) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
    end
    step();
    rst_n = 1'b1;
    repeat (3) step();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_decoder_n.md
# sel_decoder_n

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready command port, latch and timed-pulse output modes, and an optional auto-scan sequencer. It is the next-generation select decoder for driving chip-selects, LED/column strobes and mux enables. These loads need a held or timed one-hot line rather than a purely combinational decode.

## Interface
- SEL_W, 3, select width; OUT_W = 2**SEL_W (derived localparam, not overridable)
- HOLD_CYCLES, 4, cycles a line stays active in pulse mode and per scan step; legal range 1..255
- ACTIVE_LOW, 0, 1 inverts output polarity (inactive = all ones)
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s  in  SEL_W  select code
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready at rising clk
- mode  in  1  0 = latch, 1 = pulse; sampled only at a command transfer
- en  in  1  output gate; 0 forces d inactive combinationally, internal state unaffected
- scan_start  in  1  single-cycle scan request (effective only with DECODER_SCAN_EN)
- d  out  OUT_W  one-hot (or one-cold) decoded output
- busy  out  1  high in PULSE or SCAN
- scan_done  out  1  one-cycle pulse at end of scan

## Operation
- Registered one-hot value d_q; d = en ? (ACTIVE_LOW ? ~d_q : d_q) : inactive pattern.
- States: IDLE, PULSE, SCAN. in_ready = (state == IDLE); busy = !in_ready.
- IDLE, transfer with mode=0: d_q <= 1 << s; stay IDLE. The line holds until the next transfer; a new transfer replaces it.
- IDLE, transfer with mode=1: d_q <= 1 << s; cnt <= HOLD_CYCLES-1; go to PULSE.
- PULSE: cnt decrements each cycle. When cnt == 0 at the edge: d_q <= 0, go to IDLE. in_valid is ignored (not accepted).
- SCAN: step index i from 0 to OUT_W-1. d_q = 1 << i for HOLD_CYCLES cycles each. After step OUT_W-1 expires: d_q <= 0, scan_done = 1 for one cycle, go to IDLE.
- Simultaneous scan_start and in_valid in IDLE: scan wins; in_ready is still 1 that cycle, but the command is NOT consumed. To make this consistent, in_ready = IDLE & !scan_start_effective.
- scan_start outside IDLE is ignored.
- Counter width 8 bits. No arithmetic overflow is possible within the legal HOLD_CYCLES range.

## Timing
- Reset (async, immediate): state IDLE, d_q = 0, so d is the inactive pattern (all 0, or all 1 if ACTIVE_LOW). Also cnt = 0, i = 0, busy = 0, scan_done = 0, in_ready = 1.
- Latency: transfer at edge k drives d from edge k onward (1-cycle registered latency from command to output).
- Pulse mode: d is active for exactly HOLD_CYCLES cycles. in_ready returns high in the same cycle d clears, so back-to-back pulses have no gap beyond that cycle.
- HOLD_CYCLES = 1: pulse mode produces a single-cycle strobe, and the state returns to IDLE at the next edge.
- Scan length: OUT_W*HOLD_CYCLES cycles of active output. scan_done is asserted in the first IDLE cycle after the scan.
- Reset asserted mid-PULSE or mid-SCAN aborts at once. No scan_done is issued.
- en toggles only mask d. Timers keep running.

## Configuration
- DECODER_SCAN_EN defined: SCAN state, step counter and scan_done logic are compiled in.
- Undefined: the scan_start port exists but is ignored, scan_done is tied to 0, and the SCAN state is unreachable and removed. Latch and pulse behaviour are unchanged.

## Test plan
- Reset, then latch s=3'b101 in mode 0 -> d = 8'b0010_0000 from the next cycle, held for 20 cycles. Then latch s=3'b000 -> d = 8'b0000_0001.
- Pulse s=3'b011, HOLD_CYCLES=4 -> d = 8'b0000_1000 for exactly 4 cycles, busy high for 4 cycles, then d = 0. An in_valid held during the pulse is accepted only after busy falls.
- Sweep all 8 codes in pulse mode with HOLD_CYCLES=1 -> one single-cycle strobe per code, each exactly one-hot.
- DECODER_SCAN_EN, scan_start and in_valid in the same cycle -> scan runs: d walks bit0 through bit7, 4 cycles each (32 cycles). scan_done pulses once, then the pending command is accepted.
- en=0 during a latched s=3'b110 -> d = 0 while en is low; d = 8'b0100_0000 again when en rises. With ACTIVE_LOW=1: d = 8'hFF while en is low, 8'b1011_1111 when en is high.
- rst_n dropped mid-scan at step 3 -> d goes inactive immediately with no clock edge, scan_done stays 0, and in_ready = 1 after release.
